// File: rtl/count_dir_pkg.sv
// Shared types for the up/down count-stream decoder: FSM states, step classes and
// the direction encoding, which matches the counter's en input.
package count_dir_pkg;

  typedef enum logic [1:0] {S_EMPTY, S_SYNC, S_TRACK} state_t;
  typedef enum logic [1:0] {STEP_UP, STEP_DOWN, STEP_BAD} step_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/count_step_classify.sv
// Classifies one sample-to-sample transition of a WIDTH-bit up/down count.
// A +1 step takes priority, so when WIDTH=1 every change counts as UP.
module count_step_classify
  import count_dir_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output step_t            step_class,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] delta_s;

  // Modular difference, then class and max<->0 crossing.
  always_comb begin
    delta_s    = cur - prev;
    step_class = STEP_BAD;
    wrap       = 1'b0;
    if (delta_s == ONE) begin
      step_class = STEP_UP;
      wrap       = (prev == ALL_ONES) && (cur == ZERO);
    end else if (delta_s == ALL_ONES) begin
      step_class = STEP_DOWN;
      wrap       = (prev == ZERO) && (cur == ALL_ONES);
    end else begin
      step_class = STEP_BAD;
      wrap       = 1'b0;
    end
  end

endmodule

// File: rtl/count_dir_decoder.sv
// Monitor for an up/down count stream: recovers direction, lock status and
// legal/illegal step pulses, with saturating reversal and error statistics.
module count_dir_decoder
  import count_dir_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAT_W = 8,
  parameter int LOCK_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_count,
  output logic              dir,
  output logic              dir_valid,
  output logic              locked,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic [STAT_W-1:0] reversals,
  output logic [STAT_W-1:0] errors
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);

  state_t             state_r;
  logic [WIDTH-1:0]   prev_r;
  logic [RUN_W-1:0]   run_r;
  logic               dir_r;
  logic               dir_valid_r;
  logic               locked_r;
  logic               step_r;
  logic               wrap_r;
  logic               err_r;
  logic [STAT_W-1:0]  reversals_r;
  logic [STAT_W-1:0]  errors_r;

  step_t              cls_s;
  logic               wrap_s;
  logic               step_dir_s;
  logic [RUN_W-1:0]   run_inc_s;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev       (prev_r),
    .cur        (in_count),
    .step_class (cls_s),
    .wrap       (wrap_s)
  );

  // Direction implied by a legal step and the saturating run increment.
  always_comb begin
    step_dir_s = (cls_s == STEP_UP) ? DIR_UP : DIR_DOWN;
    run_inc_s  = (run_r >= RUN_MAX) ? RUN_MAX : run_r + RUN_ONE;
  end

  // Decoder FSM with registered outputs; pulses drop unless a sample sets them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_EMPTY;
      prev_r      <= {WIDTH{1'b0}};
      run_r       <= {RUN_W{1'b0}};
      dir_r       <= DIR_DOWN;
      dir_valid_r <= 1'b0;
      locked_r    <= 1'b0;
      step_r      <= 1'b0;
      wrap_r      <= 1'b0;
      err_r       <= 1'b0;
      reversals_r <= {STAT_W{1'b0}};
      errors_r    <= {STAT_W{1'b0}};
    end else begin
      step_r <= 1'b0;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
      if (in_valid) begin
        prev_r <= in_count;
        case (state_r)
          S_EMPTY: begin
            state_r <= S_SYNC;
          end
          S_SYNC: begin
            if (cls_s == STEP_BAD) begin
              err_r    <= 1'b1;
              errors_r <= sat_inc(errors_r);
            end else begin
              state_r     <= S_TRACK;
              dir_r       <= step_dir_s;
              dir_valid_r <= 1'b1;
              run_r       <= RUN_ONE;
              locked_r    <= (RUN_ONE >= RUN_MAX);
              step_r      <= 1'b1;
              wrap_r      <= wrap_s;
            end
          end
          S_TRACK: begin
            if (cls_s == STEP_BAD) begin
              // Lose sync but keep dir so the last known direction stays visible.
              state_r     <= S_SYNC;
              dir_valid_r <= 1'b0;
              locked_r    <= 1'b0;
              run_r       <= {RUN_W{1'b0}};
              err_r       <= 1'b1;
              errors_r    <= sat_inc(errors_r);
            end else if (step_dir_s == dir_r) begin
              run_r    <= run_inc_s;
              locked_r <= (run_inc_s >= RUN_MAX);
              step_r   <= 1'b1;
              wrap_r   <= wrap_s;
            end else begin
              dir_r       <= step_dir_s;
              reversals_r <= sat_inc(reversals_r);
              run_r       <= RUN_ONE;
              locked_r    <= (RUN_ONE >= RUN_MAX);
              step_r      <= 1'b1;
              wrap_r      <= wrap_s;
            end
          end
          default: begin
            state_r     <= S_EMPTY;
            dir_valid_r <= 1'b0;
            locked_r    <= 1'b0;
            run_r       <= {RUN_W{1'b0}};
          end
        endcase
      end else begin
        prev_r <= prev_r;
      end
    end
  end

  assign dir        = dir_r;
  assign dir_valid  = dir_valid_r;
  assign locked     = locked_r;
  assign step_pulse = step_r;
  assign wrap_pulse = wrap_r;
  assign err_pulse  = err_r;
  assign reversals  = reversals_r;
  assign errors     = errors_r;

endmodule

// File: tb/tb_count_dir_decoder.sv
// Bench for count_dir_decoder: directed vector table, gapped and saturation
// sequences, then random traffic against an arithmetic reference model.
module tb_count_dir_decoder;

  localparam int WIDTH  = 8;
  localparam int STAT_W = 8;
  localparam int LOCK_N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [WIDTH-1:0]  in_count;
  logic              dir, dir_valid, locked, step_pulse, wrap_pulse, err_pulse;
  logic [STAT_W-1:0] reversals, errors;

  always #5 clk = ~clk;

  count_dir_decoder #(.WIDTH(WIDTH), .STAT_W(STAT_W), .LOCK_N(LOCK_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_count   (in_count),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .locked     (locked),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .reversals  (reversals),
    .errors     (errors)
  );

  typedef struct {
    bit          r;
    bit          v;
    logic [7:0]  c;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: plain integers, no notion of the RTL encoding.
  bit m_has_prev, m_track, m_dir, m_st, m_wr, m_er;
  int m_prev, m_run, m_rev, m_errs;

  function automatic logic [21:0] pk(bit d, bit dv, bit lk, bit st, bit wr, bit er, int rv, int ec);
    return {d, dv, lk, st, wr, er, 8'(rv), 8'(ec)};
  endfunction

  function automatic void add(bit r, bit v, int c, logic [21:0] e);
    vec_t t;
    t.r = r; t.v = v; t.c = 8'(c); t.exp = e;
    tbl.push_back(t);
  endfunction

  function automatic logic [21:0] dut_vec();
    return {dir, dir_valid, locked, step_pulse, wrap_pulse, err_pulse, reversals, errors};
  endfunction

  function automatic logic [21:0] model_vec();
    return pk(m_dir, m_track, m_track && (m_run >= LOCK_N), m_st, m_wr, m_er, m_rev, m_errs);
  endfunction

  function automatic void model_step(bit r, bit v, int c);
    int  delta;
    bit  up, dn, d;
    m_st = 1'b0; m_wr = 1'b0; m_er = 1'b0;
    if (r) begin
      m_has_prev = 1'b0; m_track = 1'b0; m_dir = 1'b0;
      m_prev = 0; m_run = 0; m_rev = 0; m_errs = 0;
    end else if (v) begin
      if (m_has_prev) begin
        delta = (c - m_prev + 256) % 256;
        up = (delta == 1);
        dn = (delta == 255);
        if (up || dn) begin
          d    = up;
          m_st = 1'b1;
          m_wr = (up && m_prev == 255 && c == 0) || (dn && m_prev == 0 && c == 255);
          if (m_track && d != m_dir) begin
            m_rev = (m_rev < 255) ? m_rev + 1 : 255;
            m_run = 1;
          end else if (m_track) begin
            m_run = (m_run < LOCK_N) ? m_run + 1 : LOCK_N;
          end else begin
            m_run = 1;
          end
          m_track = 1'b1;
          m_dir   = d;
        end else begin
          m_er    = 1'b1;
          m_errs  = (m_errs < 255) ? m_errs + 1 : 255;
          m_track = 1'b0;
          m_run   = 0;
        end
      end
      m_has_prev = 1'b1;
      m_prev     = c;
    end
  endfunction

  task automatic check(string name, logic [21:0] act, logic [21:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One clock: drive inputs, advance the model, sample the response just after the edge.
  task automatic drive(bit r, bit v, int c);
    rst      = r;
    in_valid = v;
    in_count = 8'(c);
    model_step(r, v, c);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  int r_i, v_i, k_i, c_i;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_count = 8'd0;
    model_step(1'b1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", dut_vec(), pk(0, 0, 0, 0, 0, 0, 0, 0));

    // Up run to lock, then an idle cycle.
    add(1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 1, pk(1, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 2, pk(1, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 3, pk(1, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 4, pk(1, 1, 1, 1, 0, 0, 0, 0));
    add(0, 0, 9, pk(1, 1, 1, 0, 0, 0, 0, 0));
    // Reset while locked, then down run through the 0->255 wrap.
    add(1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 2, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 1, pk(0, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 0, pk(0, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 255, pk(0, 1, 0, 1, 1, 0, 0, 0));
    add(0, 1, 254, pk(0, 1, 1, 1, 0, 0, 0, 0));
    // Reversal.
    add(1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 10, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 11, pk(1, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 12, pk(1, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 11, pk(0, 1, 0, 1, 0, 0, 1, 0));
    // Illegal step, then resync.
    add(1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 5, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 6, pk(1, 1, 0, 1, 0, 0, 0, 0));
    add(0, 1, 9, pk(1, 0, 0, 0, 0, 1, 0, 1));
    add(0, 1, 10, pk(1, 1, 0, 1, 0, 0, 0, 1));
    add(0, 1, 10, pk(1, 0, 0, 0, 0, 1, 0, 2));
    add(0, 1, 12, pk(1, 0, 0, 0, 0, 1, 0, 3));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].v, int'(tbl[i].c));
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Gapped down stream: pulses stay low in the gaps, end result matches ungapped run.
    drive(1, 0, 0);
    foreach (tbl[i]) if (i >= 8 && i <= 12) begin
      drive(0, 1, int'(tbl[i].c));
      check("gap_sample", dut_vec(), tbl[i].exp);
      for (int g = 0; g < 3; g++) begin
        drive(0, 0, $urandom_range(0, 255));
        check("gap_idle", dut_vec(), model_vec());
      end
    end
    check("gap_final", dut_vec(), pk(0, 1, 1, 0, 0, 0, 0, 0));

    // Saturation of errors (repeated value) and reversals (alternating 0/1).
    drive(1, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 1, 77);
    check("errors_sat", dut_vec(), pk(0, 0, 0, 0, 0, 1, 0, 255));
    drive(1, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 1, i % 2);
    check("reversals_sat", dut_vec(), model_vec());
    check("reversals_255", {14'd0, reversals}, 22'd255);

    // Random traffic biased towards legal steps so locks and wraps occur.
    drive(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r_i = ($urandom_range(0, 149) == 0) ? 1 : 0;
      v_i = ($urandom_range(0, 9) < 7) ? 1 : 0;
      k_i = $urandom_range(0, 9);
      if (k_i < 6)       c_i = m_dir ? (m_prev + 1) % 256 : (m_prev + 255) % 256;
      else if (k_i < 7)  c_i = m_dir ? (m_prev + 255) % 256 : (m_prev + 1) % 256;
      else if (k_i < 8)  c_i = m_prev;
      else               c_i = $urandom_range(0, 255);
      drive(r_i[0], v_i[0], c_i);
      check("random", dut_vec(), model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
